// File: rtl/hex_display_scanner_if.sv
// rtl/hex_display_scanner_if.sv - host load handshake bundle for hex_display_scanner
//
// Purpose: carries the packed hex value and its valid/ready handshake from the
//          host into the scanner's pending buffer.
// Signals:
//   data_in    [4*NUM_DIGITS-1:0]  packed hex value, digit 0 in bits [3:0]
//   load_valid                     host offers data_in
//   load_ready                     scanner can accept data_in
// Modports: master = host side, slave = scanner side.

interface hex_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic                    load_valid;
    logic                    load_ready;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - time-multiplexed hex 7-segment scanner with frame-aligned updates
//
// Purpose: shares one combinational hex-to-7-segment decoder across NUM_DIGITS
//          common-anode digits. One nibble is presented per scan slot, the decoded
//          segments are registered to the pins together with the active-low digit
//          enable. Host data is staged in a pending buffer and only applied at a
//          frame wrap so a frame never mixes old and new digits.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   host        slave modport: data_in / load_valid / load_ready
//   blank_mask  per-digit force-dark, sampled live
//   hex_nibble  nibble driven to the shared decoder
//   seg7_in     [0:6] a..g active-low from the shared decoder
//   seg7_out    [0:6] a..g active-low to the pins
//   an_n        active-low digit enables, one-hot-low
//   frame_done  one-cycle pulse after the last slot of a frame ends

module hex_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hex_display_scanner_if.slave     host,
    input  logic [NUM_DIGITS-1:0]    blank_mask,
    output logic [3:0]               hex_nibble,
    input  logic [0:6]               seg7_in,
    output logic [0:6]               seg7_out,
    output logic [NUM_DIGITS-1:0]    an_n,
    output logic                     frame_done
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_full;

    logic tick;
    logic frame_wrap;
    logic blanked;

    assign tick       = (prescaler == PW'(SCAN_DIV - 1));
    assign frame_wrap = tick && (idx == IW'(NUM_DIGITS - 1));

    assign host.load_ready = ~pending_full;
    assign hex_nibble      = active[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i (i >= 1) goes dark when it and every more-significant nibble of
    // the displayed value are zero; digit 0 always shows so zero reads "0".
    logic [NUM_DIGITS-1:0] lz_blank;

    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero  = upper_zero & (active[4*i +: 4] == 4'h0);
            lz_blank[i] = upper_zero;
        end
    end
`else
    logic [NUM_DIGITS-1:0] lz_blank;
    assign lz_blank = '0;
`endif

    assign blanked = blank_mask[idx] | lz_blank[idx];

    // Scan timing: prescaler defines the slot, idx the digit within a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            if (tick) begin
                prescaler <= '0;
                if (idx == IW'(NUM_DIGITS - 1)) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // Pending buffer. A capture can only happen while the buffer is empty, and
    // the frame-wrap apply only happens while it is full, so the two never
    // collide; data captured on a wrap tick waits for the following wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            if (frame_wrap && pending_full) begin
                active       <= pending;
                pending_full <= 1'b0;
            end
            if (host.load_valid && !pending_full) begin
                pending      <= host.data_in;
                pending_full <= 1'b1;
            end
        end
    end

    // Output stage: segments and enable are registered from the same idx so
    // they always change together, one cycle after idx moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg7_out   <= 7'b1111111;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            seg7_out   <= blanked ? 7'b1111111 : seg7_in;
            an_n       <= ~({{(NUM_DIGITS - 1){1'b0}}, 1'b1} << idx);
            frame_done <= frame_wrap;
        end
    end
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - scoreboard bench for hex_display_scanner

module tb_hex_display_scanner;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int FR = N * SD;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] blank_mask = '0;
    logic [3:0]   hex_nibble;
    logic [0:6]   seg7_in;
    logic [0:6]   seg7_out;
    logic [N-1:0] an_n;
    logic         frame_done;

    hex_display_scanner_if #(.NUM_DIGITS(N)) hif ();

    hex_display_scanner #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host       (hif.slave),
        .blank_mask (blank_mask),
        .hex_nibble (hex_nibble),
        .seg7_in    (seg7_in),
        .seg7_out   (seg7_out),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // External shared decoder: active-high abcdefg patterns, inverted for the anodes.
    function automatic logic [0:6] seg_of(input logic [3:0] v);
        logic [0:6] p;
        case (v)
            4'h0: p = 7'b1111110;  4'h1: p = 7'b0110000;
            4'h2: p = 7'b1101101;  4'h3: p = 7'b1111001;
            4'h4: p = 7'b0110011;  4'h5: p = 7'b1011011;
            4'h6: p = 7'b1011111;  4'h7: p = 7'b1110000;
            4'h8: p = 7'b1111111;  4'h9: p = 7'b1111011;
            4'hA: p = 7'b1110111;  4'hB: p = 7'b0011111;
            4'hC: p = 7'b1001110;  4'hD: p = 7'b0111101;
            4'hE: p = 7'b1001111;  default: p = 7'b1000111;
        endcase
        return ~p;
    endfunction

    assign seg7_in = seg_of(hex_nibble);

    typedef struct {
        logic [0:6]   seg;
        logic [N-1:0] an;
        logic         fd;
        logic         rdy;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] host_q[$];

    // Reference model: e counts rising edges since reset release.
    int          e = 0;
    logic [15:0] shown = '0;
    logic [15:0] pend = '0;
    bit          pend_full = 1'b0;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, e, $time);
        end
    endtask

    task automatic timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: wait bound expired (edge %0d)", name, e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                check("seg7_out",   32'(seg7_out),        32'(x.seg));
                check("an_n",       32'(an_n),            32'(x.an));
                check("frame_done", 32'(frame_done),      32'(x.fd));
                check("load_ready", 32'(hif.load_ready),  32'(x.rdy));
            end
        end
    end

    // Called at a negedge: drive host inputs, then predict the pins after the next edge.
    task automatic step();
        exp_t     x;
        int       slot_digit;
        bit       blk;
        bit       wrap;
        bit       accept;
        hif.load_valid = (host_q.size() > 0);
        hif.data_in    = (host_q.size() > 0) ? host_q[0] : 16'h0000;
        e++;
        slot_digit = ((e - 1) / SD) % N;
        blk = blank_mask[slot_digit];
`ifdef LEADING_ZERO_BLANK_EN
        if (slot_digit != 0 && (shown >> (4 * slot_digit)) == 16'h0000) blk = 1'b1;
`endif
        x.seg  = blk ? 7'b1111111 : seg_of(shown[4*slot_digit +: 4]);
        x.an   = ~(N'(1) << slot_digit);
        wrap   = (e % FR) == 0;
        x.fd   = wrap;
        accept = hif.load_valid && !pend_full;
        if (wrap && pend_full) begin
            shown     = pend;
            pend_full = 1'b0;
        end
        if (accept) begin
            pend      = host_q.pop_front();
            pend_full = 1'b1;
        end
        x.rdy = !pend_full;
        exp_q.push_back(x);
    endtask

    task automatic run(input int n, input bit rnd);
        repeat (n) begin
            if (rnd) begin
                if (host_q.size() == 0 && $urandom_range(0, 5) == 0) host_q.push_back(16'($urandom));
                if ($urandom_range(0, 9) == 0) blank_mask = N'($urandom);
            end
            step();
            @(negedge clk);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_seg7_out"},   32'(seg7_out),       32'h7F);
        check({tag, "_an_n"},       32'(an_n),           32'(N'('1)));
        check({tag, "_frame_done"}, 32'(frame_done),     32'h0);
        check({tag, "_load_ready"}, 32'(hif.load_ready), 32'h1);
    endtask

    // Entered and left at a negedge; asserts reset mid-cycle.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        hif.load_valid = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        shown = '0;
        pend = '0;
        pend_full = 1'b0;
        host_q.delete();
    endtask

    initial begin
        int guard;
        hif.load_valid = 1'b0;
        hif.data_in    = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Idle scanning: zeros in every slot, frame_done every FR cycles.
        run(40, 1'b0);

        // Load while idle, then a second load that must wait for the buffer.
        host_q.push_back(16'h12AF);
        run(1, 1'b0);
        host_q.push_back(16'h0003);
        run(60, 1'b0);

        // Offer data exactly on a frame-wrap edge with the buffer empty.
        guard = 0;
        while (!(host_q.size() == 0 && !pend_full && ((e + 1) % FR) == 0) && guard < 100) begin
            run(1, 1'b0);
            guard++;
        end
        if (guard >= 100) timeout("wrap_load_align");
        host_q.push_back(16'h5555);
        run(50, 1'b0);

        // Blank digit 2 for a stretch that starts mid-slot.
        run(1, 1'b0);
        blank_mask = 4'b0100;
        run(7, 1'b0);
        blank_mask = 4'b0000;
        run(20, 1'b0);

        // Randomized host traffic and blanking.
        run(600, 1'b1);
        blank_mask = '0;

        // Reset mid-slot while the pending buffer holds data.
        guard = 0;
        while (!(host_q.size() == 0 && !pend_full && (e % FR) == 1) && guard < 100) begin
            run(1, 1'b0);
            guard++;
        end
        if (guard >= 100) timeout("pending_reset_align");
        host_q.push_back(16'hBEEF);
        run(2, 1'b0);
        do_reset();
        run(40, 1'b0);

        host_q.push_back(16'h0030);
        run(60, 1'b0);
        run(200, 1'b1);

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
